// File: rtl/branch_ctrl_pkg.sv
// Shared opcode and state definitions for the branch controller.
// Imported by the top, the return stack and the benches.
package branch_ctrl_pkg;

  localparam logic [3:0] BR_NOP  = 4'h0;
  localparam logic [3:0] BR_JMP  = 4'h1;
  localparam logic [3:0] BR_JC   = 4'h2;
  localparam logic [3:0] BR_JNC  = 4'h3;
  localparam logic [3:0] BR_JZ   = 4'h4;
  localparam logic [3:0] BR_JNZ  = 4'h5;
  localparam logic [3:0] BR_JB   = 4'h6;
  localparam logic [3:0] BR_JNB  = 4'h7;
  localparam logic [3:0] BR_CALL = 4'h8;
  localparam logic [3:0] BR_RET  = 4'h9;
  localparam logic [3:0] BR_HLT  = 4'hA;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  // True when op is a jump opcode whose condition holds.
  // Flags are only looked at by the conditional forms.
  function automatic logic jump_hit(
    input logic [3:0] op,
    input logic       c,
    input logic       z,
    input logic       b
  );
    logic hit;
    hit = 1'b0;
    case (op)
      BR_JMP:  hit = 1'b1;
      BR_JC:   hit = c;
      BR_JNC:  hit = ~c;
      BR_JZ:   hit = z;
      BR_JNZ:  hit = ~z;
      BR_JB:   hit = b;
      BR_JNB:  hit = ~b;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// LIFO of return addresses for CALL/RET.
// Ports: clk, rst (sync, high), push/push_data, pop, data (top), full, empty.
module ret_stack
  import branch_ctrl_pkg::*;
#(
  parameter int PC_W        = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] data,
  output logic            full,
  output logic            empty
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int MEM_N = 1 << IDX_W;

  logic [PC_W-1:0] mem [MEM_N];
  logic [SP_W-1:0] sp;
  logic [SP_W-1:0] sp_m1;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign sp_m1  = sp - SP_W'(1);
  assign wr_idx = sp[IDX_W-1:0];
  assign rd_idx = sp_m1[IDX_W-1:0];

  assign full  = (sp == SP_W'(STACK_DEPTH));
  assign empty = (sp == '0);
  assign data  = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= '0;
    end else if (push && !full) begin
      mem[wr_idx] <= push_data;
      sp          <= sp + SP_W'(1);
    end else if (pop && !empty) begin
      sp <= sp_m1;
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// PC sequencer: conditional jumps on flag_c/z/b, HALT, optional CALL/RET.
// Ports: clk, branch_rst, flags, branch_en/op/target, pc_stall ->
//   pc, branch_taken, halted, stack_err.
// Define BRANCH_CALL_STACK_EN to build the return-address stack.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int PC_W        = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            branch_rst,
  input  logic            flag_c,
  input  logic            flag_z,
  input  logic            flag_b,
  input  logic            branch_en,
  input  logic [3:0]      branch_op,
  input  logic [PC_W-1:0] branch_target,
  input  logic            pc_stall,
  output logic [PC_W-1:0] pc,
  output logic            branch_taken,
  output logic            halted,
  output logic            stack_err
);

  state_t          state;
  state_t          state_nxt;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_nxt;
  logic [PC_W-1:0] pc_inc;
  logic            taken_q;
  logic            taken_nxt;
  logic            advance;
  logic            op_hlt;
  logic            op_jmp;

  assign pc_inc  = pc_q + PC_W'(1);
  assign advance = (state == ST_RUN) && !pc_stall && branch_en;
  assign op_hlt  = advance && (branch_op == BR_HLT);
  assign op_jmp  = advance &&
                   jump_hit(branch_op, flag_c, flag_z, flag_b);

`ifdef BRANCH_CALL_STACK_EN
  logic            op_call;
  logic            op_ret;
  logic            push;
  logic            pop;
  logic            err_set;
  logic            err_q;
  logic [PC_W-1:0] stk_data;
  logic            stk_full;
  logic            stk_empty;

  assign op_call = advance && (branch_op == BR_CALL);
  assign op_ret  = advance && (branch_op == BR_RET);

  ret_stack #(
    .PC_W        (PC_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .rst       (branch_rst),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .data      (stk_data),
    .full      (stk_full),
    .empty     (stk_empty)
  );
`endif

  // State register
  always_ff @(posedge clk) begin
    if (branch_rst) begin
      state   <= ST_RUN;
      pc_q    <= '0;
      taken_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc_q    <= pc_nxt;
      taken_q <= taken_nxt;
    end
  end

  // Next state
  always_comb begin
    state_nxt = state;
    if (op_hlt) state_nxt = ST_HALT;
  end

  // Next PC / taken / stack control
  always_comb begin
    pc_nxt    = pc_q;
    taken_nxt = 1'b0;
`ifdef BRANCH_CALL_STACK_EN
    push      = 1'b0;
    pop       = 1'b0;
    err_set   = 1'b0;
`endif
    if ((state == ST_RUN) && !pc_stall) begin
      pc_nxt = pc_inc;
      unique case (1'b1)
        op_hlt: pc_nxt = pc_q;
        op_jmp: begin
          pc_nxt    = branch_target;
          taken_nxt = 1'b1;
        end
`ifdef BRANCH_CALL_STACK_EN
        op_call: begin
          if (stk_full) begin
            err_set = 1'b1;
          end else begin
            push      = 1'b1;
            pc_nxt    = branch_target;
            taken_nxt = 1'b1;
          end
        end
        op_ret: begin
          if (stk_empty) begin
            err_set = 1'b1;
          end else begin
            pop       = 1'b1;
            pc_nxt    = stk_data;
            taken_nxt = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef BRANCH_CALL_STACK_EN
  always_ff @(posedge clk) begin
    if (branch_rst) err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end
  assign stack_err = err_q;
`else
  assign stack_err = 1'b0;
`endif

  // Outputs
  assign pc           = pc_q;
  assign branch_taken = taken_q;
  assign halted       = (state == ST_HALT);

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed steps plus random
// traffic against a queue-based reference model.
module tb_branch_ctrl;
  import branch_ctrl_pkg::*;

  localparam int PC_W  = 8;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            branch_rst;
  logic            flag_c;
  logic            flag_z;
  logic            flag_b;
  logic            branch_en;
  logic [3:0]      branch_op;
  logic [PC_W-1:0] branch_target;
  logic            pc_stall;
  logic [PC_W-1:0] pc;
  logic            branch_taken;
  logic            halted;
  logic            stack_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_pc;
  logic       m_taken;
  logic       m_halt;
  logic       m_err;
  logic [7:0] m_stk[$];

`ifdef BRANCH_CALL_STACK_EN
  localparam bit HAS_STK = 1'b1;
`else
  localparam bit HAS_STK = 1'b0;
`endif

  always #5 clk = ~clk;

  branch_ctrl #(
    .PC_W        (PC_W),
    .STACK_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .branch_rst    (branch_rst),
    .flag_c        (flag_c),
    .flag_z        (flag_z),
    .flag_b        (flag_b),
    .branch_en     (branch_en),
    .branch_op     (branch_op),
    .branch_target (branch_target),
    .pc_stall      (pc_stall),
    .pc            (pc),
    .branch_taken  (branch_taken),
    .halted        (halted),
    .stack_err     (stack_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: what one clock edge does, per the opcode table.
  task automatic model_edge();
    logic [7:0] nxt;
    logic       tk;
    if (branch_rst) begin
      m_pc = 0; m_taken = 0; m_halt = 0; m_err = 0;
      m_stk.delete();
      return;
    end
    if (m_halt || pc_stall) begin
      m_taken = 0;
      return;
    end
    nxt = m_pc + 8'd1;
    tk  = 0;
    if (branch_en) begin
      case (branch_op)
        4'h1: tk = 1;
        4'h2: tk = flag_c;
        4'h3: tk = !flag_c;
        4'h4: tk = flag_z;
        4'h5: tk = !flag_z;
        4'h6: tk = flag_b;
        4'h7: tk = !flag_b;
        4'h8: if (HAS_STK) begin
          if (m_stk.size() < DEPTH) begin
            m_stk.push_back(m_pc + 8'd1);
            tk = 1;
          end else m_err = 1;
        end
        4'h9: if (HAS_STK) begin
          if (m_stk.size() > 0) nxt = m_stk.pop_back();
          else m_err = 1;
        end
        4'hA: begin
          m_halt = 1;
          nxt = m_pc;
        end
        default: ;
      endcase
      if (branch_op == 4'h9 && HAS_STK && nxt != m_pc + 8'd1)
        tk = 1;
    end
    m_pc    = tk && branch_op != 4'h9 ? branch_target : nxt;
    m_taken = tk;
  endtask

  task automatic step(input logic rst, input logic en,
                      input logic [3:0] op, input logic [7:0] tgt,
                      input logic st, input logic c,
                      input logic z, input logic b);
    branch_rst = rst; branch_en = en; branch_op = op;
    branch_target = tgt; pc_stall = st;
    flag_c = c; flag_z = z; flag_b = b;
    @(posedge clk);
    model_edge();
    #1;
    chk("pc", 32'(pc), 32'(m_pc));
    chk("taken", 32'(branch_taken), 32'(m_taken));
    chk("halted", 32'(halted), 32'(m_halt));
    chk("stack_err", 32'(stack_err), 32'(m_err));
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_pc", 32'(pc), 32'h0);
    seq(5);
    chk("seq_pc5", 32'(pc), 32'h5);

    step(0, 1, BR_JC, 8'h40, 0, 1, 0, 0);
    chk("jc_hit", 32'(pc), 32'h40);
    step(0, 1, BR_JC, 8'h10, 0, 0, 0, 0);
    chk("jc_miss", 32'(pc), 32'h41);
    for (int op = 2; op <= 7; op++)
      for (int f = 0; f < 2; f++)
        step(0, 1, 4'(op), 8'h60 + 8'(op), 0, f[0], f[0], f[0]);

    step(0, 1, BR_JMP, 8'hFF, 0, 0, 0, 0);
    seq(1);
    chk("wrap", 32'(pc), 32'h0);
    step(0, 1, BR_JMP, 8'h10, 1, 0, 0, 0);
    seq(1);
    chk("no_defer", 32'(pc), 32'h1);

    step(0, 1, BR_JMP, 8'h05, 0, 0, 0, 0);
    step(0, 1, BR_CALL, 8'h20, 0, 0, 0, 0);
    step(0, 1, BR_RET, 8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      step(0, 1, BR_CALL, 8'h80 + 8'(i * 16), 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      step(0, 1, BR_RET, 8'h00, 0, 0, 0, 0);

    step(0, 1, BR_JMP, 8'h0A, 0, 0, 0, 0);
    step(0, 1, BR_HLT, 8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      step(0, 1, BR_JMP, 8'h33, 0, i[0], i[1], i[0]);
    chk("halt_pc", 32'(pc), 32'h0A);
    step(1, 0, 0, 0, 0, 0, 0, 0);

    step(0, 1, BR_CALL, 8'h30, 0, 0, 0, 0);
    step(1, 1, BR_CALL, 8'h50, 0, 0, 0, 0);
    step(0, 1, BR_RET, 8'h00, 0, 0, 0, 0);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 39) == 0, 1'($urandom),
           4'($urandom), 8'($urandom), $urandom_range(0, 7) == 0,
           1'($urandom), 1'($urandom), 1'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
